// File: rtl/hilo_write_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_write_unit_if
//   Bundles the EX-stage request signals and the HI/LO register-file write
//   port of the HI/LO producer unit.
//
//   Request side (driven by the pipeline / master):
//     op_valid  EX holds a HI/LO-writing instruction (held while stalled)
//     op[2:0]   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//     src_a     rs value (multiplicand, dividend, MTHI/MTLO data)
//     src_b     rt value (multiplier, divisor)
//     flush     cancels any in-flight operation
//   Response side (driven by the unit / slave):
//     busy      combinational stall request
//     hi_we     HI write pulse (registered)
//     lo_we     LO write pulse (registered)
//     wdata_hi  HI write data (registered)
//     wdata_lo  LO write data (registered)
// ---------------------------------------------------------------------------
interface hilo_write_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata_hi;
    logic [WIDTH-1:0] wdata_lo;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  busy, hi_we, lo_we, wdata_hi, wdata_lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output busy, hi_we, lo_we, wdata_hi, wdata_lo
    );
endinterface

// File: rtl/hilo_write_unit.sv
// ---------------------------------------------------------------------------
// hilo_write_unit
//   Producer side of the HI/LO register file. Executes MULT, MULTU, DIV,
//   DIVU, MTHI and MTLO issued from EX and emits single-cycle write pulses
//   with data toward the HI/LO regfile. Multiply and divide are iterative
//   (one bit per cycle) and hold busy high until the result is written.
//
//   Ports:
//     clk     rising-edge clock
//     resetn  synchronous, active-low reset
//     bus     hilo_write_unit_if.slave (op_valid, op, src_a, src_b, flush
//             in; busy, hi_we, lo_we, wdata_hi, wdata_lo out)
//
//   Timing:
//     MUL/DIV: accept C0, iterate C1..C32, write pulse C33, busy C0..C32.
//     MTHI/MTLO: write pulse in C1, busy never asserted.
//
//   Build option:
//     MD_FAST_MUL_EN  when defined, the multiply completes in one MUL-state
//                     cycle using a single-cycle 32x32 multiplier (pulse in
//                     C2, busy C0..C1). Divide is unaffected.
// ---------------------------------------------------------------------------
module hilo_write_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              resetn,
    hilo_write_unit_if.slave  bus
);
    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    // Shared datapath register:
    //   MUL: {partial product high, remaining multiplier bits}
    //   DIV: {partial remainder, remaining dividend / quotient bits}
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    // Raw dividend, needed as HI on divide-by-zero.
    logic [WIDTH-1:0]   dividend_reg, dividend_next;
    logic               neg_q_reg, neg_q_next;     // negate product / quotient
    logic               neg_r_reg, neg_r_next;     // negate remainder
    logic               div_zero_reg, div_zero_next;
    logic               hi_we_reg, hi_we_next;
    logic               lo_we_reg, lo_we_next;
    logic [WIDTH-1:0]   wdata_hi_reg, wdata_hi_next;
    logic [WIDTH-1:0]   wdata_lo_reg, wdata_lo_next;
    logic               busy;

    // -----------------------------------------------------------------------
    // Operand conditioning at accept: signed ops (MULT, DIV) have op[0]=0.
    // -----------------------------------------------------------------------
    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign signed_op = ~bus.op[0];
    assign a_mag = (signed_op && bus.src_a[WIDTH-1]) ? (-bus.src_a) : bus.src_a;
    assign b_mag = (signed_op && bus.src_b[WIDTH-1]) ? (-bus.src_b) : bus.src_b;

    // -----------------------------------------------------------------------
    // Multiply datapath
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_result;

`ifdef MD_FAST_MUL_EN
    // Whole magnitude product in one cycle; the multiplier magnitude sits in
    // the low half of acc_reg exactly as for the iterative form.
    assign mul_prod = {{WIDTH{1'b0}}, opnd_reg} * {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};
`else
    // Radix-2 shift-add: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift the whole thing right.
    // After WIDTH steps acc holds the full magnitude product.
    logic [WIDTH:0] mul_sum;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    assign mul_prod = {mul_sum, acc_reg[WIDTH-1:1]};
`endif

    assign mul_result = neg_q_reg ? (-mul_prod) : mul_prod;

    // -----------------------------------------------------------------------
    // Restoring divide: shift the next dividend bit into the remainder, try
    // subtracting the divisor, keep the difference if it did not borrow and
    // shift the success bit into the quotient.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   div_q_fix;
    logic [WIDTH-1:0]   div_r_fix;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, opnd_reg};
    assign div_ok    = ~div_trial[WIDTH+1];
    // Either value is below the divisor, so the low WIDTH bits are exact.
    assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_step  = {div_rem, acc_reg[WIDTH-2:0], div_ok};

    assign div_q_fix = neg_q_reg ? (-div_step[WIDTH-1:0]) : div_step[WIDTH-1:0];
    assign div_r_fix = neg_r_reg ? (-div_step[2*WIDTH-1:WIDTH])
                                 : div_step[2*WIDTH-1:WIDTH];

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        opnd_next     = opnd_reg;
        dividend_next = dividend_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        div_zero_next = div_zero_reg;
        hi_we_next    = 1'b0;
        lo_we_next    = 1'b0;
        wdata_hi_next = wdata_hi_reg;
        wdata_lo_next = wdata_lo_reg;
        busy          = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // flush wins over op_valid: nothing is accepted that cycle.
                if (bus.op_valid && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            busy          = 1'b1;
                            cnt_next      = '0;
                            dividend_next = bus.src_a;
                            neg_q_next    = signed_op & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                            neg_r_next    = signed_op & bus.src_a[WIDTH-1];
                            div_zero_next = (bus.src_b == '0);
                            if (bus.op[1]) begin
                                state_next = ST_DIV;
                                acc_next   = {{WIDTH{1'b0}}, a_mag};
                                opnd_next  = b_mag;
                            end else begin
                                state_next = ST_MUL;
                                acc_next   = {{WIDTH{1'b0}}, b_mag};
                                opnd_next  = a_mag;
                            end
                        end
                        OP_MTHI: begin
                            hi_we_next    = 1'b1;
                            wdata_hi_next = bus.src_a;
                        end
                        OP_MTLO: begin
                            lo_we_next    = 1'b1;
                            wdata_lo_next = bus.src_a;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                busy = 1'b1;
`ifdef MD_FAST_MUL_EN
                {wdata_hi_next, wdata_lo_next} = mul_result;
                hi_we_next = 1'b1;
                lo_we_next = 1'b1;
                state_next = ST_DONE;
`else
                acc_next = mul_prod;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    {wdata_hi_next, wdata_lo_next} = mul_result;
                    hi_we_next = 1'b1;
                    lo_we_next = 1'b1;
                    state_next = ST_DONE;
                end
`endif
            end

            ST_DIV: begin
                busy     = 1'b1;
                acc_next = div_step;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    if (div_zero_reg) begin
                        // Fixed divide-by-zero result, independent of sign.
                        wdata_hi_next = dividend_reg;
                        wdata_lo_next = {WIDTH{1'b1}};
                    end else begin
                        wdata_hi_next = div_r_fix;
                        wdata_lo_next = div_q_fix;
                    end
                    hi_we_next = 1'b1;
                    lo_we_next = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // The stalled instruction is still presented here; ignore it.
                state_next = ST_IDLE;
            end
        endcase

        // Flush cancels whatever was about to be written, MTHI/MTLO included.
        if (bus.flush) begin
            state_next    = ST_IDLE;
            hi_we_next    = 1'b0;
            lo_we_next    = 1'b0;
            wdata_hi_next = wdata_hi_reg;
            wdata_lo_next = wdata_lo_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_we_reg    <= 1'b0;
            lo_we_reg    <= 1'b0;
            wdata_hi_reg <= '0;
            wdata_lo_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            opnd_reg     <= opnd_next;
            dividend_reg <= dividend_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            div_zero_reg <= div_zero_next;
            hi_we_reg    <= hi_we_next;
            lo_we_reg    <= lo_we_next;
            wdata_hi_reg <= wdata_hi_next;
            wdata_lo_reg <= wdata_lo_next;
        end
    end

    assign bus.busy     = busy;
    assign bus.hi_we    = hi_we_reg;
    assign bus.lo_we    = lo_we_reg;
    assign bus.wdata_hi = wdata_hi_reg;
    assign bus.wdata_lo = wdata_lo_reg;

endmodule

// File: tb/tb_hilo_write_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_write_unit
//   Self-checking bench for hilo_write_unit. Results are predicted with
//   plain 64-bit arithmetic (signed/unsigned multiply, / and %) plus the
//   divide-by-zero rule; latencies come from the documented cycle counts.
// ---------------------------------------------------------------------------
module tb_hilo_write_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    hilo_write_unit_if #(.WIDTH(32)) bus();

    hilo_write_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference result {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [31:0] uq, ur;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (op)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    uq = a / b;
                    ur = a % b;
                    r  = {ur, uq};
                end
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        return op[1] ? DIV_LAT : MUL_LAT;
    endfunction

    // Issue one multiply/divide, hold it like a stalled pipeline would, and
    // report what was observed. Operands are scrambled while busy to show
    // they are latched. Returns one cycle after the pulse, op_valid still high.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic busy_p,
                          output logic hwe, output logic lwe, output logic [31:0] hi,
                          output logic [31:0] lo, output logic we_after, output int pulse_cyc);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        lat = -1; busy_cnt = 0; busy_p = 1'b1; hwe = 1'b0; lwe = 1'b0;
        hi = '0; lo = '0; we_after = 1'b1; pulse_cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            if (bus.hi_we || bus.lo_we) begin
                lat = k; busy_p = bus.busy; hwe = bus.hi_we; lwe = bus.lo_we;
                hi = bus.wdata_hi; lo = bus.wdata_lo; pulse_cyc = cyc;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            we_after = bus.hi_we | bus.lo_we;
        end
    endtask

    task automatic test_reset;
        bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.hi_we, bus.lo_we, bus.wdata_hi, bus.wdata_lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b hi_we=%b lo_we=%b hi=%h lo=%h, want all 0",
                     bus.busy, bus.hi_we, bus.lo_we, bus.wdata_hi, bus.wdata_lo);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_mthi_mtlo;
        logic [2:0]  ops[3]  = '{3'd4, 3'd5, 3'd6};
        logic [31:0] vals[3] = '{32'h1234_5678, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        for (int i = 0; i < 3; i++) begin
            prev_hi = bus.wdata_hi;
            prev_lo = bus.wdata_lo;
            bus.op_valid = 1'b1; bus.op = ops[i]; bus.src_a = vals[i]; bus.src_b = $urandom;
            #1;
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL mt_busy op=%0d: got %b want 0", ops[i], bus.busy);
            end
            @(posedge clk); #1;
            bus.op_valid = 1'b0;
            $display("txn op=%0d a=%h hi_we=%b lo_we=%b hi=%h lo=%h", ops[i], vals[i],
                     bus.hi_we, bus.lo_we, bus.wdata_hi, bus.wdata_lo);
            checks++;
            if ({bus.hi_we, bus.lo_we} !== {ops[i] == 3'd4, ops[i] == 3'd5}) begin
                errors++; $display("FAIL mt_we op=%0d: got hi_we=%b lo_we=%b", ops[i], bus.hi_we, bus.lo_we);
            end
            checks++;
            if ({bus.wdata_hi, bus.wdata_lo} !== {(ops[i] == 3'd4) ? vals[i] : prev_hi,
                                                  (ops[i] == 3'd5) ? vals[i] : prev_lo}) begin
                errors++; $display("FAIL mt_data op=%0d: got hi=%h lo=%h", ops[i], bus.wdata_hi, bus.wdata_lo);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.hi_we, bus.lo_we, bus.busy} !== 3'b000) begin
                errors++; $display("FAIL mt_pulse_end op=%0d: got we=%b%b busy=%b want 000",
                                   ops[i], bus.hi_we, bus.lo_we, bus.busy);
            end
        end
    endtask

    task automatic test_muldiv_directed;
        logic [2:0]  t_op[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd0, 3'd1, 3'd2};
        logic [31:0] t_a[10]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                                  32'h55, 32'hFFFF_FF00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] t_b[10]  = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFF_FFFF,
                                  32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] t_hi[10] = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'd1, 32'd0,
                                  32'h55, 32'hFFFF_FF00, 32'h4000_0000, 32'hFFFF_FFFE, 32'd1};
        logic [31:0] t_lo[10] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFD};
        int lat, bc, pc;
        logic bp, hwe, lwe, wa;
        logic [31:0] hi, lo;
        for (int i = 0; i < 10; i++) begin
            run_md(t_op[i], t_a[i], t_b[i], lat, bc, bp, hwe, lwe, hi, lo, wa, pc);
            bus.op_valid = 1'b0;
            #1;
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h lat=%0d busy_cycles=%0d",
                     t_op[i], t_a[i], t_b[i], hi, lo, lat, bc);
            checks++;
            if (lat !== exp_lat(t_op[i]) || bc !== exp_lat(t_op[i])) begin
                errors++; $display("FAIL dir_latency #%0d: got pulse C%0d busy %0d, want %0d",
                                   i, lat, bc, exp_lat(t_op[i]));
            end
            checks++;
            if ({hi, lo} !== {t_hi[i], t_lo[i]}) begin
                errors++; $display("FAIL dir_result #%0d: got hi=%h lo=%h want hi=%h lo=%h",
                                   i, hi, lo, t_hi[i], t_lo[i]);
            end
            checks++;
            if ({hwe, lwe, bp, wa, bus.busy} !== 5'b11000) begin
                errors++; $display("FAIL dir_pulse #%0d: got we=%b%b busy_at_pulse=%b we_after=%b busy_after=%b",
                                   i, hwe, lwe, bp, wa, bus.busy);
            end
        end
    endtask

    task automatic test_muldiv_random;
        int lat, bc, pc;
        logic bp, hwe, lwe, wa;
        logic [31:0] hi, lo, a, b;
        logic [2:0]  op;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 30);
            exp = model(op, a, b);
            run_md(op, a, b, lat, bc, bp, hwe, lwe, hi, lo, wa, pc);
            bus.op_valid = 1'b0;
            #1;
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", op, a, b, hi, lo, lat);
            checks++;
            if (lat !== exp_lat(op) || bc !== exp_lat(op)) begin
                errors++; $display("FAIL rnd_latency #%0d: got pulse C%0d busy %0d, want %0d",
                                   i, lat, bc, exp_lat(op));
            end
            checks++;
            if ({hwe, lwe, hi, lo} !== {2'b11, exp}) begin
                errors++; $display("FAIL rnd_result #%0d op=%0d: got we=%b%b hi=%h lo=%h want hi=%h lo=%h",
                                   i, op, hwe, lwe, hi, lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_flush;
        int lat, bc, pc, we_seen;
        logic bp, hwe, lwe, wa;
        logic [31:0] hi, lo;
        // Flush in cycle 10 of a DIV.
        we_seen = 0;
        bus.op_valid = 1'b1; bus.op = 3'd2; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.hi_we || bus.lo_we) we_seen++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.op_valid = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.hi_we, bus.lo_we} !== 3'b000) begin
            errors++; $display("FAIL flush_div_next: got busy=%b we=%b%b want 000", bus.busy, bus.hi_we, bus.lo_we);
        end
        // MULT 5 x 6 presented the cycle after the flush.
        run_md(3'd0, 32'd5, 32'd6, lat, bc, bp, hwe, lwe, hi, lo, wa, pc);
        bus.op_valid = 1'b0;
        $display("txn flush-then-mult hi=%h lo=%h lat=%0d", hi, lo, lat);
        checks++;
        if ({hi, lo} !== 64'd30 || lat !== MUL_LAT) begin
            errors++; $display("FAIL flush_then_mult: got hi=%h lo=%h lat=%0d want 0/1e lat %0d",
                               hi, lo, lat, MUL_LAT);
        end
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.hi_we || bus.lo_we) we_seen++;
        end
        checks++;
        if (we_seen !== 0) begin
            errors++; $display("FAIL flush_div_no_we: got %0d stray pulses want 0", we_seen);
        end
        // flush beats op_valid in IDLE (multiply not accepted).
        bus.op_valid = 1'b1; bus.op = 3'd1; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL flush_accept_busy: got %b want 0", bus.busy);
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        we_seen = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.busy || bus.hi_we || bus.lo_we) we_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (we_seen !== 0) begin
            errors++; $display("FAIL flush_accept_none: got %0d active cycles want 0", we_seen);
        end
        // flush on the edge that would register an MTHI pulse.
        bus.op_valid = 1'b1; bus.op = 3'd4; bus.src_a = 32'hCAFE_F00D; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        checks++;
        if ({bus.hi_we, bus.lo_we} !== 2'b00 || bus.wdata_hi === 32'hCAFE_F00D) begin
            errors++; $display("FAIL flush_mthi: got hi_we=%b hi=%h want no write", bus.hi_we, bus.wdata_hi);
        end
        $display("txn flush scenarios done");
    endtask

    task automatic test_reset_mid;
        int stray;
        bus.op_valid = 1'b1; bus.op = 3'd0; bus.src_a = 32'd123; bus.src_b = 32'd456;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.hi_we, bus.lo_we, bus.wdata_hi, bus.wdata_lo} !== 67'd0) begin
            errors++; $display("FAIL reset_mid_mult: got busy=%b we=%b%b hi=%h lo=%h want all 0",
                               bus.busy, bus.hi_we, bus.lo_we, bus.wdata_hi, bus.wdata_lo);
        end
        resetn = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.hi_we || bus.lo_we || bus.busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL reset_mid_abort: got %0d active cycles after reset want 0", stray);
        end
        $display("txn reset mid-mult done");
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, bc, pc1, pc2;
        logic bp, hwe, lwe, wa;
        logic [31:0] hi1, lo1, hi2, lo2;
        logic [63:0] e1, e2;
        e1 = model(3'd0, 32'hFFFF_FFFE, 32'd3);
        e2 = model(3'd1, 32'h0001_0001, 32'h0000_FFFF);
        run_md(3'd0, 32'hFFFF_FFFE, 32'd3, lat1, bc, bp, hwe, lwe, hi1, lo1, wa, pc1);
        run_md(3'd1, 32'h0001_0001, 32'h0000_FFFF, lat2, bc, bp, hwe, lwe, hi2, lo2, wa, pc2);
        bus.op_valid = 1'b0;
        $display("txn back-to-back pulses at %0d and %0d, r1=%h_%h r2=%h_%h", pc1, pc2, hi1, lo1, hi2, lo2);
        checks++;
        if (pc2 - pc1 !== MUL_LAT + 1 || lat1 !== MUL_LAT || lat2 !== MUL_LAT) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles apart want %0d", pc2 - pc1, MUL_LAT + 1);
        end
        checks++;
        if ({hi1, lo1, hi2, lo2} !== {e1, e2}) begin
            errors++; $display("FAIL b2b_results: got %h_%h %h_%h want %h %h", hi1, lo1, hi2, lo2, e1, e2);
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        test_reset();
        test_mthi_mtlo();
        test_muldiv_directed();
        test_muldiv_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
